// File: rtl/pixels_vector_pkg.sv
// Shared definitions for the two-entry, four-lane pixel vector bank.
package pixels_vector_pkg;

    localparam int DATA_W_DEFAULT = 32;
    localparam int LANES          = 4;
    localparam int DEPTH          = 2;

    // One stored pixel vector at the default lane width; lane 0 holds pixel 1.
    typedef logic [LANES-1:0][DATA_W_DEFAULT-1:0] pixel_vec_t;

endpackage

// File: rtl/pixel_vector_entry.sv
// One four-lane pixel register with asynchronous clear and a shared load enable.
module pixel_vector_entry
    import pixels_vector_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          load_i,
    input  logic [LANES-1:0][DATA_W-1:0]  d_i,
    output logic [LANES-1:0][DATA_W-1:0]  q_o
);

    logic [LANES-1:0][DATA_W-1:0] lanes_q;
    logic [LANES-1:0][DATA_W-1:0] lanes_d;

    // Next value: all lanes load together or all hold.
    always_comb begin
        lanes_d = lanes_q;
        if (load_i) begin
            lanes_d = d_i;
        end
    end

    // Lane storage; reset takes priority over a coincident load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lanes_q <= '0;
        end else begin
            lanes_q <= lanes_d;
        end
    end

    assign q_o = lanes_q;

endmodule

// File: rtl/pixels_vector_bank.sv
// Two-entry bank of four-lane pixel vectors: one write port, one combinational read port.
module pixels_vector_bank
    import pixels_vector_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_pos,
    input  logic              wr_pos,
    input  logic              we,
    input  logic [DATA_W-1:0] wd1,
    input  logic [DATA_W-1:0] wd2,
    input  logic [DATA_W-1:0] wd3,
    input  logic [DATA_W-1:0] wd4,
    output logic [DATA_W-1:0] out1,
    output logic [DATA_W-1:0] out2,
    output logic [DATA_W-1:0] out3,
    output logic [DATA_W-1:0] out4
);

    logic [LANES-1:0][DATA_W-1:0] wr_vec;
    logic [LANES-1:0][DATA_W-1:0] rd_vec;
    logic [LANES-1:0][DATA_W-1:0] entry_q [DEPTH];
    logic [DEPTH-1:0]             load;

    assign wr_vec[0] = wd1;
    assign wr_vec[1] = wd2;
    assign wr_vec[2] = wd3;
    assign wr_vec[3] = wd4;

    // Write decode: only the entry addressed by wr_pos sees a load.
    always_comb begin
        load = '0;
        for (int i = 0; i < DEPTH; i++) begin
            load[i] = we && (int'(wr_pos) == i);
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_entry
        pixel_vector_entry #(
            .DATA_W (DATA_W)
        ) u_entry (
            .clk    (clk),
            .rst    (rst),
            .load_i (load[g]),
            .d_i    (wr_vec),
            .q_o    (entry_q[g])
        );
    end

    // Read mux straight off the registers; a same-entry write shows up only after its edge.
    always_comb begin
        rd_vec = entry_q[rd_pos];
    end

    assign out1 = rd_vec[0];
    assign out2 = rd_vec[1];
    assign out3 = rd_vec[2];
    assign out4 = rd_vec[3];

endmodule

// File: tb/tb_pixels_vector_bank.sv
// Directed bench for pixels_vector_bank with hand-computed expectations.
module tb_pixels_vector_bank;

    localparam int DW = 32;

    logic          clk;
    logic          rst;
    logic          rd_pos;
    logic          wr_pos;
    logic          we;
    logic [DW-1:0] wd1, wd2, wd3, wd4;
    logic [DW-1:0] out1, out2, out3, out4;

    int n_checks;
    int n_fail;

    pixels_vector_bank #(.DATA_W(DW)) dut (
        .clk    (clk),
        .rst    (rst),
        .rd_pos (rd_pos),
        .wr_pos (wr_pos),
        .we     (we),
        .wd1    (wd1),
        .wd2    (wd2),
        .wd3    (wd3),
        .wd4    (wd4),
        .out1   (out1),
        .out2   (out2),
        .out3   (out3),
        .out4   (out4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_lane(input string tag, input int lane,
                              input logic [DW-1:0] obs, input logic [DW-1:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s lane%0d observed=%0d expected=%0d", tag, lane, obs, exp_v);
        end
    endtask

    task automatic check4(input string tag, input logic [DW-1:0] e1, input logic [DW-1:0] e2,
                          input logic [DW-1:0] e3, input logic [DW-1:0] e4);
        check_lane(tag, 1, out1, e1);
        check_lane(tag, 2, out2, e2);
        check_lane(tag, 3, out3, e3);
        check_lane(tag, 4, out4, e4);
    endtask

    task automatic set_wd(input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic [DW-1:0] c, input logic [DW-1:0] d);
        wd1 = a; wd2 = b; wd3 = c; wd4 = d;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1; we = 1'b0; rd_pos = 1'b0; wr_pos = 1'b0;
        set_wd(0, 0, 0, 0);

        // Reset state, both read positions
        repeat (2) @(negedge clk);
        rd_pos = 1'b0; #1 check4("reset_rd0", 0, 0, 0, 0);
        rd_pos = 1'b1; #1 check4("reset_rd1", 0, 0, 0, 0);

        // Write while reset held is ignored
        we = 1'b1; wr_pos = 1'b1; set_wd(9, 9, 9, 9);
        @(posedge clk); #1 check4("write_in_reset", 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0; we = 1'b0;

        // Write position 0
        @(negedge clk);
        we = 1'b1; wr_pos = 1'b0; set_wd(15, 45, 74, 82);
        @(posedge clk); #1;
        we = 1'b0; rd_pos = 1'b0;
        #1 check4("wr_pos0", 15, 45, 74, 82);

        // Write position 1, entry 0 unchanged
        @(negedge clk);
        we = 1'b1; wr_pos = 1'b1; set_wd(16, 46, 75, 83);
        @(posedge clk); #1;
        we = 1'b0; rd_pos = 1'b1;
        #1 check4("wr_pos1_rd1", 16, 46, 75, 83);
        rd_pos = 1'b0;
        #1 check4("wr_pos1_rd0", 15, 45, 74, 82);

        // Hold with changing write data; rd_pos toggles without a clock edge
        for (int i = 0; i < 10; i++) begin
            set_wd($urandom, $urandom, $urandom, $urandom);
            wr_pos = i[0];
            #4;
            rd_pos = ~rd_pos;
            #1;
            if (rd_pos) check4("hold_rd1", 16, 46, 75, 83);
            else        check4("hold_rd0", 15, 45, 74, 82);
            #5;
        end

        // Same-position write: old value until the edge, new after
        @(negedge clk);
        rd_pos = 1'b0; wr_pos = 1'b0; we = 1'b1; set_wd(1, 2, 3, 4);
        #1 check4("same_pos_before", 15, 45, 74, 82);
        @(posedge clk); #1 check4("same_pos_after", 1, 2, 3, 4);
        we = 1'b0;
        rd_pos = 1'b1;
        #1 check4("same_pos_other", 16, 46, 75, 83);

        // Asynchronous reset between edges
        @(posedge clk); #3;
        rst = 1'b1;
        #1 check4("async_rst_rd1", 0, 0, 0, 0);
        rd_pos = 1'b0;
        #1 check4("async_rst_rd0", 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rd_pos = 1'b0; #1 check4("post_rst_rd0", 0, 0, 0, 0);
        rd_pos = 1'b1; #1 check4("post_rst_rd1", 0, 0, 0, 0);

        // Reset coinciding with a write edge wins
        @(negedge clk);
        we = 1'b1; wr_pos = 1'b1; set_wd(7, 8, 9, 10);
        @(posedge clk); rst = 1'b1;
        #1;
        @(negedge clk);
        rst = 1'b0; we = 1'b0; rd_pos = 1'b1;
        #1 check4("rst_wins", 0, 0, 0, 0);

        // First write after release lands normally
        @(negedge clk);
        we = 1'b1; wr_pos = 1'b1; set_wd(100, 200, 300, 400);
        @(posedge clk); #1;
        we = 1'b0;
        #1 check4("first_write_after_rst", 100, 200, 300, 400);
        rd_pos = 1'b0;
        #1 check4("first_write_other", 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
